// File: rtl/joystick_sampler.sv
// rtl/joystick_sampler.sv - ADC-driven two-axis joystick sampler with box-car averaging and hysteresis flags
module joystick_sampler #(
    parameter int HI_THRESH = 2000,
    parameter int LO_THRESH = 700,
    parameter int HYST      = 64,
    parameter int AVG_LOG2  = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        new_frame,
    output logic        cmd_valid,
    output logic [4:0]  cmd_channel,
    input  logic        cmd_ready,
    input  logic        rsp_valid,
    input  logic [4:0]  rsp_channel,
    input  logic [11:0] rsp_data,
    output logic [11:0] y_axis,
    output logic [11:0] x_axis,
    output logic        movefor,
    output logic        moveback,
    output logic        turnleft,
    output logic        turnright,
    output logic        dir_valid
);

    localparam int          AW     = 12 + AVG_LOG2;
    localparam logic [9:0]  TO_CNT = 10'(TIMEOUT);
    localparam logic [11:0] HI_SET = 12'(HI_THRESH);
    localparam logic [11:0] HI_CLR = 12'(HI_THRESH - HYST);
    localparam logic [11:0] LO_SET = 12'(LO_THRESH);
    localparam logic [11:0] LO_CLR = 12'(LO_THRESH + HYST);

    typedef enum logic [1:0] {REQ_Y, WAIT_Y, REQ_X, WAIT_X} state_t;

    state_t state, state_nx;
    logic   armed;
    logic [9:0] tcnt;

    // Index 0 is the Y (channel 1) axis, index 1 the X (channel 2) axis.
    logic [1:0][AW-1:0]       acc;
    logic [1:0][AVG_LOG2-1:0] scnt;
    logic [1:0][11:0]         avg;
    logic [1:0]               hi_f, lo_f, seen;

    logic          waiting, cmd_fire, take, timed_out, ax, last;
    logic [AW-1:0] sum;
    logic [11:0]   avg_new;

    assign waiting   = (state == WAIT_Y) || (state == WAIT_X);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign take      = rsp_valid && (((state == WAIT_Y) && (rsp_channel == 5'd1)) ||
                                     ((state == WAIT_X) && (rsp_channel == 5'd2)));
    assign timed_out = waiting && (tcnt == TO_CNT);
    assign ax        = (state == WAIT_X);
    assign last      = &scnt[ax];
    assign sum       = acc[ax] + AW'(rsp_data);
    assign avg_new   = 12'(sum >> AVG_LOG2);

    assign y_axis = avg[0];
    assign x_axis = avg[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= REQ_Y;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            REQ_Y:  if (cmd_fire) state_nx = WAIT_Y;
            WAIT_Y: if (take) state_nx = REQ_X; else if (timed_out) state_nx = REQ_Y;
            REQ_X:  if (cmd_fire) state_nx = WAIT_X;
            WAIT_X: if (take) state_nx = REQ_Y; else if (timed_out) state_nx = REQ_X;
            default: state_nx = REQ_Y;
        endcase
    end

    // armed keeps the command off during reset while REQ_Y is already the state.
    always_comb begin
        cmd_valid   = 1'b0;
        cmd_channel = 5'd1;
        unique case (state)
            REQ_Y:  cmd_valid = armed;
            WAIT_Y: cmd_channel = 5'd1;
            REQ_X:  begin cmd_valid = armed; cmd_channel = 5'd2; end
            WAIT_X: cmd_channel = 5'd2;
            default: cmd_channel = 5'd1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tcnt <= '0;
        else if (waiting) tcnt <= tcnt + 10'd1;
        else tcnt <= '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc  <= '0;
            scnt <= '0;
            avg  <= {2{12'd2048}};
            hi_f <= '0;
            lo_f <= '0;
            seen <= '0;
        end else if (take) begin
            if (last) begin
                acc[ax]  <= '0;
                scnt[ax] <= '0;
                avg[ax]  <= avg_new;
                seen[ax] <= 1'b1;
                if (avg_new > HI_SET) hi_f[ax] <= 1'b1;
                else if (avg_new < HI_CLR) hi_f[ax] <= 1'b0;
                if (avg_new < LO_SET) lo_f[ax] <= 1'b1;
                else if (avg_new > LO_CLR) lo_f[ax] <= 1'b0;
            end else begin
                acc[ax]  <= sum;
                scnt[ax] <= scnt[ax] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            movefor   <= 1'b0;
            moveback  <= 1'b0;
            turnleft  <= 1'b0;
            turnright <= 1'b0;
            dir_valid <= 1'b0;
        end else if (new_frame) begin
            if (&seen) begin
                movefor   <= hi_f[0];
                moveback  <= lo_f[0];
                turnleft  <= hi_f[1];
                turnright <= lo_f[1];
                dir_valid <= 1'b1;
            end else begin
                movefor   <= 1'b0;
                moveback  <= 1'b0;
                turnleft  <= 1'b0;
                turnright <= 1'b0;
                dir_valid <= 1'b0;
            end
        end else begin
            dir_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_joystick_sampler.sv
// tb/tb_joystick_sampler.sv - randomized self-checking bench for joystick_sampler
module tb_joystick_sampler;

    localparam int HI = 2000, LO = 700, HY = 64, AL = 2, TO = 15, N = 1 << AL;

    logic        clk = 1'b0, reset_n = 1'b0, new_frame = 1'b0, cmd_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [4:0]  rsp_channel = '0;
    logic [11:0] rsp_data = '0;
    logic        cmd_valid, movefor, moveback, turnleft, turnright, dir_valid;
    logic [4:0]  cmd_channel;
    logic [11:0] y_axis, x_axis;

    joystick_sampler #(.HI_THRESH(HI), .LO_THRESH(LO), .HYST(HY), .AVG_LOG2(AL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .new_frame(new_frame),
        .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
        .y_axis(y_axis), .x_axis(x_axis),
        .movefor(movefor), .moveback(moveback), .turnleft(turnleft), .turnright(turnright),
        .dir_valid(dir_valid)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: list of accepted samples per axis, mean of each full block, hysteresis on the mean.
    int m_samp[2][$];
    int m_avg[2];
    bit m_hi[2], m_lo[2], m_seen[2];

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_samp[i].delete();
            m_avg[i] = 2048; m_hi[i] = 0; m_lo[i] = 0; m_seen[i] = 0;
        end
    endfunction

    function automatic bit m_accept(int a, int v);
        int s;
        m_samp[a].push_back(v);
        if (m_samp[a].size() < N) return 0;
        s = 0;
        foreach (m_samp[a][i]) s += m_samp[a][i];
        m_samp[a].delete();
        m_avg[a] = s / N;
        if (m_avg[a] > HI) m_hi[a] = 1; else if (m_avg[a] < HI - HY) m_hi[a] = 0;
        if (m_avg[a] < LO) m_lo[a] = 1; else if (m_avg[a] > LO + HY) m_lo[a] = 0;
        m_seen[a] = 1;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd(output int n);
        n = 0;
        while (!cmd_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic issue(input int ch);
        int n;
        cmd_ready = 1'b1;
        wait_cmd(n);
        check("cmd_valid_up", int'(cmd_valid), 1);
        check("cmd_channel", int'(cmd_channel), ch);
        tick();
        cmd_ready = 1'b0;
        check("cmd_taken", int'(cmd_valid), 0);
    endtask

    task automatic respond(input int ch, input int v, input int lat);
        repeat (lat - 1) tick();
        rsp_valid = 1'b1; rsp_channel = 5'(ch); rsp_data = 12'(v);
        tick();
        rsp_valid = 1'b0;
    endtask

    // mode 1 injects a response for the other axis before the real one.
    task automatic sample(input int a, input int v, input int lat, input int mode);
        issue(a + 1);
        if (mode == 1) begin
            rsp_valid = 1'b1; rsp_channel = 5'(2 - a); rsp_data = 12'($urandom);
            tick();
            rsp_valid = 1'b0;
            check("wrong_ch_hold", int'(cmd_valid), 0);
        end
        respond(a + 1, v, lat);
        if (m_accept(a, v)) begin
            if (a == 0) check("y_axis", int'(y_axis), m_avg[0]);
            else        check("x_axis", int'(x_axis), m_avg[1]);
        end
    endtask

    task automatic frame();
        int dv;
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        dv = (m_seen[0] && m_seen[1]) ? 1 : 0;
        check("dir_valid", int'(dir_valid), dv);
        check("flags", int'({movefor, moveback, turnleft, turnright}),
              dv ? int'({m_hi[0], m_lo[0], m_hi[1], m_lo[1]}) : 0);
        tick();
        check("dir_valid_pulse", int'(dir_valid), 0);
    endtask

    task automatic group(input int yv, input int xv);
        for (int k = 0; k < N; k++) begin
            sample(0, yv, 3, 0);
            sample(1, xv, 3, 0);
        end
    endtask

    function automatic int pick(int base);
        int v;
        v = base + $urandom_range(0, 80) - 40;
        if (v < 0) v = 0;
        if (v > 4095) v = 4095;
        return v;
    endfunction

    int bases[8] = '{2100, 1960, 1900, 650, 740, 780, 2048, 0};

    initial begin
        int n, yb, xb, stable;
        m_reset();
        repeat (3) tick();
        check("rst_cmd_valid", int'(cmd_valid), 0);
        check("rst_cmd_channel", int'(cmd_channel), 1);
        check("rst_y_axis", int'(y_axis), 2048);
        check("rst_x_axis", int'(x_axis), 2048);
        check("rst_flags", int'({movefor, moveback, turnleft, turnright, dir_valid}), 0);
        reset_n = 1'b1;

        group(2500, 1800);
        frame();
        group(1960, 600);
        frame();
        group(1900, 740);
        frame();
        group(1900, 780);
        frame();

        // wrong channel, backpressure and timeout inside one averaging block
        sample(0, 1234, 3, 1);
        sample(1, 3000, 2, 1);
        wait_cmd(n);
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_valid && cmd_channel == 5'd1) stable++;
            tick();
        end
        check("bp_stable", stable, 20);
        sample(0, 700, 3, 0);
        sample(1, 100, 3, 0);
        issue(1);
        wait_cmd(n);
        check("timeout_reissue", n, TO + 1);
        check("timeout_channel", int'(cmd_channel), 1);
        sample(0, 2222, 4, 0);
        sample(1, 555, 1, 0);
        sample(0, 4095, 5, 0);
        sample(1, 4000, 3, 0);
        frame();

        for (int g = 0; g < 6; g++) begin
            yb = bases[$urandom_range(0, 7)];
            xb = bases[$urandom_range(0, 7)];
            if (yb == 0) yb = $urandom_range(0, 4095);
            if (xb == 0) xb = $urandom_range(0, 4095);
            for (int k = 0; k < N; k++) begin
                sample(0, pick(yb), $urandom_range(1, 5), 0);
                sample(1, pick(xb), $urandom_range(1, 5), 0);
                if ($urandom_range(0, 2) == 0) frame();
            end
        end
        frame();

        // reset while waiting for a channel-2 response
        sample(0, 1500, 3, 0);
        issue(2);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        m_reset();
        check("arst_cmd_valid", int'(cmd_valid), 0);
        check("arst_cmd_channel", int'(cmd_channel), 1);
        check("arst_y_axis", int'(y_axis), 2048);
        check("arst_x_axis", int'(x_axis), 2048);
        check("arst_flags", int'({movefor, moveback, turnleft, turnright, dir_valid}), 0);
        tick();
        reset_n = 1'b1;
        rsp_valid = 1'b1; rsp_channel = 5'd2; rsp_data = 12'd4000;
        tick();
        rsp_valid = 1'b0;
        frame();
        group(2600, 2600);
        frame();
        group(500, 300);
        frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/joystick_sampler.md
# joystick_sampler

Upstream front end for player movement. Drives the modular ADC command/response streams and alternates between joystick channel 1 (forward/back axis) and channel 2 (turn axis). Each axis is box-car averaged, and hysteresis thresholds turn the averages into direction flags. Flags are latched once per `new_frame`, so the movement stage sees one stable decision per frame.

## Interface
- `HI_THRESH`, 2000: upper decision threshold (12-bit code).
- `LO_THRESH`, 700: lower decision threshold.
- `HYST`, 64: hysteresis band; must satisfy `HI_THRESH-HYST > LO_THRESH+HYST`.
- `AVG_LOG2`, 2: log2 of samples averaged per axis (1..4).
- `TIMEOUT`, 1023: cycles to wait for a response before reissuing a command.
- `clk` in 1: system clock (ADC clock-bridge output).
- `reset_n` in 1: asynchronous, active-low reset.
- `new_frame` in 1: frame strobe, one cycle high.
- `cmd_valid` out 1: ADC command valid.
- `cmd_channel` out 5: ADC channel, 1 or 2.
- `cmd_ready` in 1: ADC command ready.
- `rsp_valid` in 1: ADC response valid.
- `rsp_channel` in 5: channel of the response.
- `rsp_data` in 12: sample value.
- `y_axis` out 12: last channel-1 average.
- `x_axis` out 12: last channel-2 average.
- `movefor`, `moveback`, `turnleft`, `turnright` out 1 each: frame-latched direction flags.
- `dir_valid` out 1: one-cycle pulse on each frame latch, once both axes have produced at least one average.

## Operation
- States: `REQ_Y`, `WAIT_Y`, `REQ_X`, `WAIT_X`. Reset state is `REQ_Y`.
- **Request states:**
  - `cmd_valid`=1 and `cmd_channel` = 1 (`REQ_Y`) or 2 (`REQ_X`), both decoded from state.
  - Held stable until `cmd_valid&&cmd_ready`, then move to the matching WAIT state.
- **Wait states:**
  - `cmd_valid`=0 and `cmd_channel` holds its last value.
  - `rsp_valid` with the matching channel: accept `rsp_data` and go to the other axis's REQ state (Y→X, X→Y).
  - `rsp_valid` with a non-matching channel is discarded and the state is unchanged.
- **Timeout:** a 10-bit counter clears on entering a WAIT state and increments each WAIT cycle. When it reaches `TIMEOUT`, return to the same axis's REQ state. No sample is recorded and the accumulator is kept.
- **Averaging, per axis:**
  - Accumulator is `12+AVG_LOG2` bits wide, with a sample counter.
  - On the 2^AVG_LOG2-th accepted sample, the axis register is loaded with `(acc+sample)>>AVG_LOG2` (truncating).
  - The accumulator and counter then clear, and the axis "seen" bit sets.
- **Hysteresis, internal flags:** evaluated against the new average on the same edge the axis register loads.
  - fwd/left set when avg > `HI_THRESH`; clear when avg < `HI_THRESH-HYST`.
  - back/right set when avg < `LO_THRESH`; clear when avg > `LO_THRESH+HYST`.
  - Otherwise the flag holds. The fwd/back (and left/right) flags are mutually exclusive by construction.
- **Frame latch:** on a `clk` edge with `new_frame`=1:
  - Output flags load from the internal flags as they were before that edge.
  - `dir_valid` is 1 for the following cycle, but only if both seen bits are set; otherwise the flags load as 0.
- **Reset:** all flags, `dir_valid`, `cmd_valid`, counters, accumulators and seen bits are 0; `cmd_channel`=1; `y_axis`=`x_axis`=2048.

## Timing
- The first `cmd_valid` is high in the first cycle after `reset_n` deasserts.
- With `cmd_ready` held at 1 and a response after a fixed latency L:
  - One axis sample takes 1+L cycles.
  - An axis register updates every 2·2^AVG_LOG2 samples, i.e. every 8 samples at the default.
- Axis register and internal flag: registered on the accept edge, visible the next cycle.
- Output flags: registered on the `new_frame` edge. Minimum latency from the final accepted sample to an output flag is 2 edges (internal update, then frame latch).
- `rsp_valid` is ignored during REQ states; a response with no outstanding command is dropped.
- `reset_n` asserted mid-WAIT: immediate asynchronous return to the reset values; any late response after release is dropped.

## Test plan
- **Steady input:** ch1=2500, ch2=1800 constant, L=3, AVG_LOG2=2.
  - After 4 samples per axis: `y_axis`=2500, `x_axis`=1800.
  - Next `new_frame`: `movefor`=1, others 0, `dir_valid` pulses once.
- **Hysteresis:** ch1 averages 2500, then 1960, then 1900.
  - `movefor` stays 1 at 1960 (≥1936) and clears at 1900.
  - ch2=600 sets `turnright`; 780 (≤764? no) clears it; 740 holds it.
- **Wrong channel:** inject a ch2 response while in `WAIT_Y`.
  - It is dropped: no state change and no accumulator change.
  - The ch1 response then accepted normally.
- **Backpressure:** hold `cmd_ready` low for 20 cycles.
  - `cmd_valid`=1 and `cmd_channel`=1 stay stable throughout.
  - Exactly one command transfers when `cmd_ready` rises.
- **Timeout:** with no response, TIMEOUT=15.
  - `cmd_valid` reasserts with the same channel 16 cycles after the command transfer.
  - The partial average is preserved across the reissue.
- **Reset and first frame:** assert `reset_n` low while in `WAIT_X`.
  - Outputs immediately return to reset values.
  - A `new_frame` before both axes complete gives `dir_valid`=0 and all flags 0.
